ddr100_cmd_seq: RTL

- Command-side initiator for the DDR PHY at 100 MHz.
- Accepts single-burst user requests (ready/valid) and issues ACTIVATE, then READ or WRITE with auto-precharge on the DDR command pins.
- Drives the PHY strobes read/write/burst8 and counts PHY rvalid beats to signal read completion.
- Schedules periodic auto-refresh and enforces tRCD, recovery and tRFC with cycle counters.

---
 rtl/ddr100_pkg.sv | 29 ++
 rtl/ddr100_ref_timer.sv | 43 ++++
 rtl/ddr100_cmd_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr100_pkg.sv
// Shared types and constants for the DDR 100 MHz command sequencer.
// Optional read-timeout feature: define DDR_CMD_SEQ_RD_TMO_EN.
package ddr100_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RCD  = 3'd1,
    RDW  = 3'd2,
    REC  = 3'd3,
    RFC  = 3'd4
  } state_t;

  // Command pin encodings, ordered {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_REF   = 4'b0001;

  // Address bit carrying auto-precharge on READ/WRITE
  localparam int AP_BIT = 10;

  // Larger of two integers, used to size the shared timing counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr100_ref_timer.sv
// Free-running auto-refresh interval timer with a single pending flag.
// The flag is set on every expiry and cleared by ref_ack; an expiry that
// lands while the flag is already set is simply absorbed.
module ddr100_ref_timer #(
  parameter int T_REFI = 780
) (
  input  logic clk100m,
  input  logic phy_rst_n,
  input  logic ref_ack,
  output logic ref_pend
);

  localparam int RW = (T_REFI > 1) ? $clog2(T_REFI) : 1;

  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic          expire;

  assign expire   = (ref_cnt_q == '0);
  assign ref_pend = ref_pend_q;

  // Next-state: reload on expiry, otherwise count down; expiry wins over ack
  always_comb begin
    ref_cnt_d  = ref_cnt_q - RW'(1);
    ref_pend_d = ref_pend_q & ~ref_ack;
    if (expire) begin
      ref_cnt_d  = RW'(T_REFI - 1);
      ref_pend_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk100m or negedge phy_rst_n) begin
    if (!phy_rst_n) begin
      ref_cnt_q  <= RW'(T_REFI - 1);
      ref_pend_q <= 1'b0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
    end
  end

endmodule

// File: rtl/ddr100_cmd_seq.sv
// DDR command-side initiator: ACT followed by READ/WRITE with auto-precharge,
// PHY strobes, read-beat counting and periodic auto-refresh.
// Optional read timeout: define DDR_CMD_SEQ_RD_TMO_EN to enable rd_err.
module ddr100_cmd_seq
  import ddr100_pkg::*;
#(
  parameter int ROW_W    = 13,
  parameter int COL_W    = 10,
  parameter int BA_W     = 3,
  parameter int T_RCD    = 2,
  parameter int T_RD_REC = 6,
  parameter int T_WR_REC = 12,
  parameter int T_REFI   = 780,
  parameter int T_RFC    = 13,
  parameter int RD_TMO   = 16
) (
  input  logic             clk100m,
  input  logic             phy_rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic             req_burst8,
  input  logic [BA_W-1:0]  req_ba,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  output logic             cmd_cs_n,
  output logic             cmd_ras_n,
  output logic             cmd_cas_n,
  output logic             cmd_we_n,
  output logic [BA_W-1:0]  cmd_ba,
  output logic [ROW_W-1:0] cmd_a,
  output logic             phy_read,
  output logic             phy_write,
  output logic             phy_burst8,
  input  logic             phy_rvalid,
  output logic             rd_done,
  output logic             rd_err,
  output logic             busy
);

  localparam int CNT_MAX = max_int(max_int(max_int(T_RCD, T_RD_REC),
                                           max_int(T_WR_REC, T_RFC)), RD_TMO);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       beat_q;
  logic [3:0]       cmd_q;
  logic [BA_W-1:0]  cmd_ba_q;
  logic [ROW_W-1:0] cmd_a_q;
  logic             phy_read_q;
  logic             phy_write_q;
  logic             phy_burst8_q;
  logic             rd_done_q;
  logic             we_q;
  logic [BA_W-1:0]  ba_q;
  logic [COL_W-1:0] col_q;

  logic             ref_pend;
  logic             ref_ack;
  logic [1:0]       last_beat;
  logic [ROW_W-1:0] rw_addr;

  // Refresh interval timer; the sequencer acknowledges in the IDLE cycle
  // that launches REF
  ddr100_ref_timer #(
    .T_REFI (T_REFI)
  ) u_ref_timer (
    .clk100m   (clk100m),
    .phy_rst_n (phy_rst_n),
    .ref_ack   (ref_ack),
    .ref_pend  (ref_pend)
  );

  assign ref_ack   = (state_q == IDLE) & ref_pend;
  assign req_ready = (state_q == IDLE) & ~ref_pend;
  assign busy      = (state_q != IDLE);

  // Index of the final beat: two beats for BL4, four for BL8
  assign last_beat = phy_burst8_q ? 2'd3 : 2'd1;

  // READ/WRITE address: column in the low bits, auto-precharge on bit 10,
  // everything else zero
  genvar gi;
  generate
    for (gi = 0; gi < ROW_W; gi++) begin : g_rw_addr
      if (gi < COL_W) begin : g_col
        assign rw_addr[gi] = col_q[gi];
      end else if (gi == AP_BIT) begin : g_ap
        assign rw_addr[gi] = 1'b1;
      end else begin : g_zero
        assign rw_addr[gi] = 1'b0;
      end
    end
  endgenerate

  assign {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} = cmd_q;
  assign cmd_ba     = cmd_ba_q;
  assign cmd_a      = cmd_a_q;
  assign phy_read   = phy_read_q;
  assign phy_write  = phy_write_q;
  assign phy_burst8 = phy_burst8_q;
  assign rd_done    = rd_done_q;

`ifdef DDR_CMD_SEQ_RD_TMO_EN
  logic rd_err_q;
  assign rd_err = rd_err_q;
`else
  assign rd_err = 1'b0;
`endif

  // Sequencer FSM with registered command pins and strobes
  always_ff @(posedge clk100m or negedge phy_rst_n) begin
    if (!phy_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      beat_q       <= '0;
      cmd_q        <= CMD_NOP;
      cmd_ba_q     <= '0;
      cmd_a_q      <= '0;
      phy_read_q   <= 1'b0;
      phy_write_q  <= 1'b0;
      phy_burst8_q <= 1'b0;
      rd_done_q    <= 1'b0;
      we_q         <= 1'b0;
      ba_q         <= '0;
      col_q        <= '0;
`ifdef DDR_CMD_SEQ_RD_TMO_EN
      rd_err_q     <= 1'b0;
`endif
    end else begin
      // Pulses and command default to idle every cycle
      cmd_q       <= CMD_NOP;
      phy_read_q  <= 1'b0;
      phy_write_q <= 1'b0;
      rd_done_q   <= 1'b0;
`ifdef DDR_CMD_SEQ_RD_TMO_EN
      rd_err_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // Pending refresh takes priority over a waiting request
          if (ref_pend) begin
            cmd_q   <= CMD_REF;
            cnt_q   <= CNT_W'(T_RFC - 1);
            state_q <= RFC;
          end else if (req_valid) begin
            we_q         <= req_we;
            ba_q         <= req_ba;
            col_q        <= req_col;
            phy_burst8_q <= req_burst8;
            cmd_q        <= CMD_ACT;
            cmd_ba_q     <= req_ba;
            cmd_a_q      <= req_row;
            cnt_q        <= CNT_W'(T_RCD - 1);
            state_q      <= RCD;
          end
        end

        RCD: begin
          if (cnt_q == '0) begin
            cmd_ba_q <= ba_q;
            cmd_a_q  <= rw_addr;
            if (we_q) begin
              cmd_q       <= CMD_WRITE;
              phy_write_q <= 1'b1;
              cnt_q       <= CNT_W'(T_WR_REC - 1);
              state_q     <= REC;
            end else begin
              cmd_q      <= CMD_READ;
              phy_read_q <= 1'b1;
              beat_q     <= '0;
              cnt_q      <= CNT_W'(RD_TMO - 1);
              state_q    <= RDW;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        RDW: begin
          if (phy_rvalid) begin
            if (beat_q == last_beat) begin
              rd_done_q <= 1'b1;
              cnt_q     <= CNT_W'(T_RD_REC - 1);
              state_q   <= REC;
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end
`ifdef DDR_CMD_SEQ_RD_TMO_EN
          // Timeout only runs until the first beat shows up
          else if (beat_q == 2'd0) begin
            if (cnt_q == '0) begin
              rd_err_q <= 1'b1;
              cnt_q    <= CNT_W'(T_RD_REC - 1);
              state_q  <= REC;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
`endif
        end

        REC, RFC: begin
          if (cnt_q == '0) begin
            phy_burst8_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
